seq_detector_param: RTL and testbench
=====================================

// Module: seq_detector_param
// PURPOSE
//  Parametrised serial bit-pattern detector for the FSM benchmark family. Replaces fixed-pattern,
//  fixed-length detectors with a run-time programmable one: pattern, length and overlap mode.
//  Monitors a qualified 1-bit stream and pulses MATCH once per detected occurrence.
//  Sits between a serial front end and the event/interrupt logic.
// PARAMETERS
//  MAX_LEN   8    maximum pattern length in bits (2..32)
//  CNT_W     16   width of match counter (CONFIGURATION feature)
//  LEN_W     $clog2(MAX_LEN+1)   derived; do not override
// PORTS
//  CLK        in   1        clock, rising edge
//  RST        in   1        reset, asynchronous, active-high
//  EN         in   1        detector enable; 0 = hold in IDLE, input ignored
//  CFG_LD     in   1        load CFG_* this edge; restarts detection
//  CFG_PAT    in   MAX_LEN  pattern; PAT[LEN-1] = first bit received, PAT[0] = last
//  CFG_LEN    in   LEN_W    pattern length
//  CFG_OVL    in   1        1 = overlapping matches allowed, 0 = non-overlapping
//  IN_VLD     in   1        IN is valid this cycle
//  IN         in   1        serial data bit
//  MATCH      out  1        registered one-cycle pulse per match
//  MATCH_CNT  out  CNT_W    saturating match count (0 when feature compiled out)
// BEHAVIOUR
//  Reset: PAT=5'b10011 (zero-extended), LEN=5, OVL=1, HIST=0, FILL=0, state IDLE, MATCH=0, MATCH_CNT=0.
//  Config clamp at load: CFG_LEN 0 or 1 -> 2; CFG_LEN > MAX_LEN -> MAX_LEN.
//  Bit accept: IN_VLD & EN & !CFG_LD. On accept, HIST <= {HIST[MAX_LEN-2:0], IN}; FILL increments, saturating at LEN.
//  Hit (combinational): accept & (FILL >= LEN-1) & ({HIST,IN} low LEN bits == PAT low LEN bits).
//  MATCH: registered; high exactly in the cycle after the edge that samples the completing bit;
//   one clock wide; back-to-back hits give back-to-back pulses. MATCH=0 in every other cycle.
//  On hit: OVL=1 -> HIST/FILL continue (suffix reuse, e.g. 10011 then 0011 -> second match).
//   OVL=0 -> FILL <= 0 and HIST <= 0 on that edge; next match needs LEN fresh bits.
//  FSM (state reg, 2 bits):
//   IDLE : EN=0. HIST/FILL held; MATCH=0. EN=1 -> FILL (FILL<LEN-1) or HUNT.
//   FILL : fewer than LEN-1 bits held; accepts only shift. FILL reaches LEN-1 -> HUNT.
//   HUNT : each accepted bit may hit. OVL=0 hit -> FILL.
//   any state, EN falls -> IDLE on the next edge; the bit accepted in that cycle is still evaluated.
//  CFG_LD (priority over accept): latch clamped PAT/LEN/OVL, clear HIST, FILL, MATCH, MATCH_CNT;
//   go to FILL if EN=1, else IDLE. The IN bit of that cycle is discarded.
//  IN_VLD=0 cycles: no shift, no hit, no state change (gaps are transparent).
//  RST mid-sequence: all state to reset values immediately; partial pattern lost; no MATCH.
//  Unused PAT/HIST bits above LEN-1 never affect compare.
// CONFIGURATION
//  SEQDET_MATCH_CNT_EN defined: MATCH_CNT increments on every MATCH pulse and saturates at
//   2^CNT_W-1 (no wrap). It is cleared by RST and by CFG_LD.
//  Not defined: no counter flops; MATCH_CNT tied to 0. All other behaviour is identical.
// TESTING
//  1 Reset defaults, EN=1, IN_VLD=1, IN=1,0,0,1,1 -> MATCH=1 one cycle after 5th bit edge, else 0.
//  2 Defaults, IN=100110011 -> exactly two MATCH pulses, after bits 5 and 9 (overlap reuse).
//  3 Load PAT=101 LEN=3 OVL=1, IN=10101 -> 2 pulses; reload with OVL=0, same IN -> 1 pulse (after bit 3).
//  4 Defaults, 10011 sent with IN_VLD=0 idle cycles between bits -> single MATCH after last valid bit.
//  5 RST pulse after 1001 -> then IN=1 gives no MATCH; then full 10011 -> MATCH; CFG_LEN=0 -> LEN=2.
//  6 SEQDET_MATCH_CNT_EN, CNT_W=2, 5 matches -> MATCH_CNT 1,2,3,3,3; CFG_LD -> 0. Undefined -> always 0.

Source files
------------

// File: rtl/seq_detector_param.sv
// Run-time programmable serial pattern detector: pattern, length (2..MAX_LEN) and overlap mode.
// Define SEQDET_MATCH_CNT_EN to build the saturating MATCH_CNT counter; otherwise MATCH_CNT is 0.
module seq_detector_param #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 16,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               EN,
    input  logic               CFG_LD,
    input  logic [MAX_LEN-1:0] CFG_PAT,
    input  logic [LEN_W-1:0]   CFG_LEN,
    input  logic               CFG_OVL,
    input  logic               IN_VLD,
    input  logic               IN,
    output logic               MATCH,
    output logic [CNT_W-1:0]   MATCH_CNT
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_HUNT = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0]   LEN_ONE = LEN_W'(1);
    localparam logic [LEN_W-1:0]   LEN_MIN = LEN_W'(2);
    localparam logic [LEN_W-1:0]   LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0]   RST_LEN = LEN_W'((MAX_LEN < 5) ? MAX_LEN : 5);
    localparam logic [MAX_LEN-1:0] RST_PAT = MAX_LEN'(5'b10011);

    state_t               state_q, state_d;
    logic [MAX_LEN-1:0]   pat_q, pat_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic                 ovl_q, ovl_d;
    // The incoming bit completes the compare word, so only MAX_LEN-1 history bits are ever needed.
    logic [MAX_LEN-2:0]   hist_q, hist_d;
    logic [LEN_W-1:0]     fill_q, fill_d;
    logic                 match_q, match_d;

    logic                 accept;
    logic                 hit;
    logic [LEN_W-1:0]     len_clamped;
    logic [MAX_LEN-1:0]   cmp_word;
    logic [MAX_LEN-1:0]   len_mask;

    genvar gi;
    generate
        for (gi = 0; gi < MAX_LEN; gi++) begin : g_mask
            assign len_mask[gi] = (LEN_W'(gi) < len_q);
        end
    endgenerate

    assign accept   = IN_VLD & EN & ~CFG_LD;
    assign cmp_word = {hist_q, IN};
    assign hit      = accept && (fill_q >= (len_q - LEN_ONE)) &&
                      (((cmp_word ^ pat_q) & len_mask) == '0);

    always_comb begin
        len_clamped = CFG_LEN;
        if (CFG_LEN < LEN_MIN) begin
            len_clamped = LEN_MIN;
        end else if (CFG_LEN > LEN_MAX) begin
            len_clamped = LEN_MAX;
        end
    end

    always_comb begin
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        match_d = 1'b0;
        state_d = state_q;

        if (CFG_LD) begin
            pat_d   = CFG_PAT;
            len_d   = len_clamped;
            ovl_d   = CFG_OVL;
            hist_d  = '0;
            fill_d  = '0;
            state_d = EN ? ST_FILL : ST_IDLE;
        end else begin
            if (accept) begin
                hist_d = cmp_word[MAX_LEN-2:0];
                if (fill_q < len_q) begin
                    fill_d = fill_q + LEN_ONE;
                end
            end
            if (hit) begin
                match_d = 1'b1;
                // Non-overlapping mode: the matched bits may not seed the next match.
                if (!ovl_q) begin
                    hist_d = '0;
                    fill_d = '0;
                end
            end

            if (!EN) begin
                state_d = ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: state_d = (fill_d < (len_q - LEN_ONE)) ? ST_FILL : ST_HUNT;
                    ST_FILL: if (fill_d >= (len_q - LEN_ONE)) state_d = ST_HUNT;
                    ST_HUNT: if (hit && !ovl_q) state_d = ST_FILL;
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            pat_q   <= RST_PAT;
            len_q   <= RST_LEN;
            ovl_q   <= 1'b1;
            hist_q  <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            match_q <= match_d;
        end
    end

    assign MATCH = match_q;

`ifdef SEQDET_MATCH_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counts on the hit itself so MATCH_CNT steps in the same cycle MATCH is high.
    always_comb begin
        cnt_d = cnt_q;
        if (CFG_LD) begin
            cnt_d = '0;
        end else if (hit && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign MATCH_CNT = cnt_q;
`else
    assign MATCH_CNT = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed-vector bench for seq_detector_param (MAX_LEN=8, CNT_W=2); expectations are hand-derived.
module tb_seq_detector_param;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       EN = 1'b0;
    logic       CFG_LD = 1'b0;
    logic [7:0] CFG_PAT = '0;
    logic [3:0] CFG_LEN = '0;
    logic       CFG_OVL = 1'b0;
    logic       IN_VLD = 1'b0;
    logic       IN = 1'b0;
    logic       MATCH;
    logic [1:0] MATCH_CNT;

    int passed = 0;
    int total  = 0;

    seq_detector_param #(.MAX_LEN(8), .CNT_W(2)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .CFG_LD(CFG_LD), .CFG_PAT(CFG_PAT),
        .CFG_LEN(CFG_LEN), .CFG_OVL(CFG_OVL), .IN_VLD(IN_VLD), .IN(IN),
        .MATCH(MATCH), .MATCH_CNT(MATCH_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        IN_VLD = 1'b1;
        IN     = b;
        step();
        IN_VLD = 1'b0;
        $display("t=%0t bit=%0b match=%0b cnt=%0d", $time, b, MATCH, MATCH_CNT);
    endtask

    task automatic do_reset();
        RST = 1'b1; EN = 1'b0; CFG_LD = 1'b0; IN_VLD = 1'b0; IN = 1'b0;
        step();
        RST = 1'b0;
        step();
    endtask

    task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
        CFG_PAT = pat; CFG_LEN = len; CFG_OVL = ovl;
        CFG_LD = 1'b1; IN_VLD = 1'b1; IN = 1'b1;  // this bit must be discarded
        step();
        CFG_LD = 1'b0; IN_VLD = 1'b0;
        $display("t=%0t load pat=%b len=%0d ovl=%0b", $time, pat, len, ovl);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        step();
        total++;
        if (MATCH !== 1'b0 || MATCH_CNT !== 2'd0)
            $display("FAIL reset: match=%b cnt=%0d, required 0/0", MATCH, MATCH_CNT);
        else passed++;
        RST = 1'b0;
        step();
    endtask

    task automatic test_basic();
        logic [4:0] seq = 5'b10011;
        logic [4:0] exp = 5'b00001;
        do_reset();
        EN = 1'b1;
        for (int i = 4; i >= 0; i--) begin
            drive_bit(seq[i]);
            total++;
            if (MATCH !== exp[i]) $display("FAIL basic bit%0d: match=%b, required %b", 5 - i, MATCH, exp[i]);
            else passed++;
        end
        step();
        total++;
        if (MATCH !== 1'b0) $display("FAIL basic_width: match=%b, required 0", MATCH);
        else passed++;
    endtask

    task automatic test_overlap();
        logic [8:0] seq = 9'b100110011;
        logic [8:0] exp = 9'b000010001;
        do_reset();
        EN = 1'b1;
        for (int i = 8; i >= 0; i--) begin
            drive_bit(seq[i]);
            total++;
            if (MATCH !== exp[i]) $display("FAIL overlap bit%0d: match=%b, required %b", 9 - i, MATCH, exp[i]);
            else passed++;
        end
    endtask

    task automatic test_cfg();
        logic [4:0] seq  = 5'b10101;
        logic [4:0] exp1 = 5'b00101;
        logic [4:0] exp0 = 5'b00100;
        do_reset();
        EN = 1'b1;
        load(8'b101, 4'd3, 1'b1);
        for (int i = 4; i >= 0; i--) begin
            drive_bit(seq[i]);
            total++;
            if (MATCH !== exp1[i]) $display("FAIL cfg_ovl1 bit%0d: match=%b, required %b", 5 - i, MATCH, exp1[i]);
            else passed++;
        end
        load(8'b101, 4'd3, 1'b0);
        for (int i = 4; i >= 0; i--) begin
            drive_bit(seq[i]);
            total++;
            if (MATCH !== exp0[i]) $display("FAIL cfg_ovl0 bit%0d: match=%b, required %b", 5 - i, MATCH, exp0[i]);
            else passed++;
        end
    endtask

    task automatic test_gaps();
        logic [4:0] seq = 5'b10011;
        logic       exp;
        do_reset();
        EN = 1'b1;
        for (int i = 4; i >= 0; i--) begin
            drive_bit(seq[i]);
            exp = (i == 0);
            total++;
            if (MATCH !== exp) $display("FAIL gaps bit%0d: match=%b, required %b", 5 - i, MATCH, exp);
            else passed++;
            for (int g = 0; g < 2; g++) begin
                step();
                total++;
                if (MATCH !== 1'b0) $display("FAIL gaps idle%0d_%0d: match=%b, required 0", 5 - i, g, MATCH);
                else passed++;
            end
        end
    endtask

    task automatic test_rst_mid();
        logic [5:0] seq = 6'b110011;
        logic [5:0] exp = 6'b000001;
        logic [4:0] seq2 = 5'b01101;
        logic [4:0] exp2 = 5'b01001;
        logic [7:0] seq3 = 8'hA5;
        do_reset();
        EN = 1'b1;
        drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b0); drive_bit(1'b1);
        #2 RST = 1'b1;
        #2 RST = 1'b0;
        total++;
        if (MATCH !== 1'b0) $display("FAIL rst_mid_pulse: match=%b, required 0", MATCH);
        else passed++;
        step();
        // a lone 1 first (would have completed 10011), then a full 10011
        for (int i = 5; i >= 0; i--) begin
            drive_bit(seq[i]);
            total++;
            if (MATCH !== exp[i]) $display("FAIL rst_mid bit%0d: match=%b, required %b", 6 - i, MATCH, exp[i]);
            else passed++;
        end
        load(8'b01, 4'd0, 1'b1);  // clamps to LEN=2
        for (int i = 4; i >= 0; i--) begin
            drive_bit(seq2[i]);
            total++;
            if (MATCH !== exp2[i]) $display("FAIL len_lo bit%0d: match=%b, required %b", 5 - i, MATCH, exp2[i]);
            else passed++;
        end
        load(8'hA5, 4'd15, 1'b1);  // clamps to LEN=8
        for (int i = 7; i >= 0; i--) begin
            drive_bit(seq3[i]);
            total++;
            if (MATCH !== (i == 0)) $display("FAIL len_hi bit%0d: match=%b, required %b", 8 - i, MATCH, (i == 0));
            else passed++;
        end
    endtask

    task automatic test_en();
        do_reset();
        EN = 1'b1;
        drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b0);
        EN = 1'b0;
        drive_bit(1'b1); drive_bit(1'b1);
        total++;
        if (MATCH !== 1'b0) $display("FAIL en_low: match=%b, required 0", MATCH);
        else passed++;
        EN = 1'b1;
        drive_bit(1'b1);
        total++;
        if (MATCH !== 1'b0) $display("FAIL en_resume4: match=%b, required 0", MATCH);
        else passed++;
        drive_bit(1'b1);
        total++;
        if (MATCH !== 1'b1) $display("FAIL en_resume5: match=%b, required 1", MATCH);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_cnt;
        do_reset();
        EN = 1'b1;
        load(8'b11, 4'd2, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            drive_bit(1'b1);
`ifdef SEQDET_MATCH_CNT_EN
            exp_cnt = (k <= 1) ? 2'd0 : ((k - 1 >= 3) ? 2'd3 : 2'(k - 1));
`else
            exp_cnt = 2'd0;
`endif
            total++;
            if (MATCH !== (k >= 2)) $display("FAIL b2b_match bit%0d: match=%b, required %b", k, MATCH, (k >= 2));
            else passed++;
            total++;
            if (MATCH_CNT !== exp_cnt) $display("FAIL b2b_cnt bit%0d: cnt=%0d, required %0d", k, MATCH_CNT, exp_cnt);
            else passed++;
        end
        load(8'b11, 4'd2, 1'b1);
        total++;
        if (MATCH !== 1'b0 || MATCH_CNT !== 2'd0)
            $display("FAIL cnt_clear: match=%b cnt=%0d, required 0/0", MATCH, MATCH_CNT);
        else passed++;
    endtask

    initial begin
        #1;
        test_reset();
        test_basic();
        test_overlap();
        test_cfg();
        test_gaps();
        test_rst_mid();
        test_en();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
